uart_tx_engine: RTL

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame constants, divisor
// width and the transmitter FSM state type.
// Build option: UART_TX_PARITY_EN adds a parity bit (11-bit frame) and the
// PARITY state. Without it the frame is 10 bits and PARITY does not exist.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W     = 16;

  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  // Index of the last data bit, used to leave the DATA state.
  localparam logic [2:0] UART_LAST_BIT = 3'(UART_DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;
`else
  localparam int UART_FRAME_BITS = 10;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised.
// Writes while full and reads while empty are ignored. Read data is the
// current head entry (show-ahead), so a pop consumes the visible word.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Flags come from the registered count, so they reflect pre-edge state.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding a start/data/(parity)/stop
// serialiser with a programmable bit period of cfg_div+1 clocks.
// Build option: UART_TX_PARITY_EN adds cfg_parity_odd and a parity bit.
// The serial line is registered from the FSM's combinational line value,
// so the line trails the state by one clock. dbg_state exposes the FSM.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  tx_wr,
  input  logic [7:0]            tx_wdata,
  input  logic                  cfg_en,
  input  logic [UART_DIV_W-1:0] cfg_div,
`ifdef UART_TX_PARITY_EN
  input  logic                  cfg_parity_odd,
`endif
  output logic                  uart_tx,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  tx_busy,
  output logic                  ctrl_tif,
  output uart_state_t           dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_t               state;
  uart_state_t               state_next;
  logic [UART_DIV_W-1:0]     div_cnt;
  logic [UART_DIV_W-1:0]     div_next;
  logic [2:0]                bit_cnt;
  logic [2:0]                bit_next;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] shift_next;
  logic                      line_next;
  logic                      tif_next;
  logic                      pop;
  logic                      bit_done;
  logic                      fifo_has_data;
  logic [7:0]                fifo_rdata;
  logic [CW-1:0]             fifo_count;
`ifdef UART_TX_PARITY_EN
  logic                      par_bit;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (pclk),
    .rst     (preset),
    .wr_en   (tx_wr),
    .wr_data (tx_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (fifo_count)
  );

  assign fifo_has_data = (fifo_count != '0);
  assign bit_done      = (div_cnt == '0);
  assign tx_busy       = (state != IDLE);
  assign dbg_state     = state;

  // Next-state, bit timing and line value; a pop always reloads the divisor.
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    line_next  = UART_STOP_LEVEL;
    tif_next   = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_en && fifo_has_data) begin
          pop        = 1'b1;
          state_next = START;
          div_next   = cfg_div;
          bit_next   = '0;
          shift_next = fifo_rdata;
        end
      end
      START: begin
        line_next = UART_START_LEVEL;
        if (bit_done) begin
          state_next = DATA;
          div_next   = cfg_div;
        end else begin
          div_next = div_cnt - 1'b1;
        end
      end
      DATA: begin
        line_next = shift_reg[0];
        if (bit_done) begin
          div_next   = cfg_div;
          shift_next = shift_reg >> 1;
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == UART_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          div_next = div_cnt - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_next = par_bit ^ cfg_parity_odd;
        if (bit_done) begin
          state_next = STOP;
          div_next   = cfg_div;
        end else begin
          div_next = div_cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        line_next = UART_STOP_LEVEL;
        if (bit_done) begin
          if (cfg_en && fifo_has_data) begin
            pop        = 1'b1;
            state_next = START;
            div_next   = cfg_div;
            bit_next   = '0;
            shift_next = fifo_rdata;
          end else begin
            state_next = IDLE;
            tif_next   = !fifo_has_data;
          end
        end else begin
          div_next = div_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters, serial line and interrupt registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      uart_tx   <= UART_STOP_LEVEL;
      ctrl_tif  <= 1'b0;
    end else begin
      state     <= state_next;
      div_cnt   <= div_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      uart_tx   <= line_next;
      ctrl_tif  <= tif_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Data-bit XOR captured when the byte is popped; sense is applied on output.
  always_ff @(posedge pclk) begin
    if (preset) begin
      par_bit <= 1'b0;
    end else if (pop) begin
      par_bit <= ^fifo_rdata;
    end
  end
`endif

endmodule
